// File: rtl/axi_bus_arbiter.sv
// axi_bus_arbiter: shares one AXI master port between ICache, DCache and uncached requesters.
`timescale 1ns/1ps
module axi_bus_arbiter #(
  parameter int IC_LINE_WORDS = 8,
  parameter int DC_LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ic_rd_req,
  input  logic        dc_rd_req,
  input  logic        uc_rd_req,
  input  logic [31:0] ic_rd_addr,
  input  logic [31:0] dc_rd_addr,
  input  logic [31:0] uc_rd_addr,
  input  logic [2:0]  uc_rd_size,
  input  logic [2:0]  uc_wr_size,
  output logic        ic_rd_gnt,
  output logic        dc_rd_gnt,
  output logic        uc_rd_gnt,
  output logic        ic_rd_valid,
  output logic        dc_rd_valid,
  output logic        uc_rd_valid,
  output logic        rd_last,
  output logic [31:0] rd_data,
  input  logic        dc_wr_req,
  input  logic        uc_wr_req,
  input  logic [31:0] dc_wr_addr,
  input  logic [31:0] uc_wr_addr,
  input  logic [31:0] dc_wr_data,
  input  logic [31:0] uc_wr_data,
  input  logic [3:0]  dc_wr_strb,
  input  logic [3:0]  uc_wr_strb,
  output logic        dc_wr_next,
  output logic        uc_wr_next,
  output logic        dc_wr_done,
  output logic        uc_wr_done,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);
  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;
  localparam logic [1:0] OWN_IC = 2'd1, OWN_DC = 2'd2, OWN_UC = 2'd3;
  localparam logic [7:0] IC_LEN = 8'(IC_LINE_WORDS - 1);
  localparam logic [7:0] DC_LEN = 8'(DC_LINE_WORDS - 1);

  r_state_t    r_state, r_next;
  w_state_t    w_state, w_next;
  logic [1:0]  rd_owner, wr_owner, rd_pick, wr_pick;
  logic [31:0] ar_addr_q, aw_addr_q;
  logic [7:0]  ar_len_q, aw_len_q, beat;
  logic [2:0]  ar_size_q, aw_size_q;
  logic        uc_rd_ok, rd_hs, rd_beat, wr_beat, wr_resp;

  // an uncached load must not overtake an uncached store still in flight
  assign uc_rd_ok = uc_rd_req && !(w_state != W_IDLE && wr_owner == OWN_UC);
  assign rd_pick  = uc_rd_ok ? OWN_UC : dc_rd_req ? OWN_DC : ic_rd_req ? OWN_IC : 2'd0;
  assign wr_pick  = uc_wr_req ? OWN_UC : dc_wr_req ? OWN_DC : 2'd0;

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  r_next = (rd_pick != 2'd0) ? R_AR : R_IDLE;
      R_AR:    r_next = arready ? R_DATA : R_AR;
      R_DATA:  r_next = (rvalid && rlast) ? R_IDLE : R_DATA;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= R_IDLE;
      rd_owner  <= 2'd0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_size_q <= '0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && rd_pick != 2'd0) begin
        rd_owner  <= rd_pick;
        ar_addr_q <= (rd_pick == OWN_UC) ? uc_rd_addr : (rd_pick == OWN_DC) ? dc_rd_addr : ic_rd_addr;
        ar_len_q  <= (rd_pick == OWN_UC) ? 8'd0 : (rd_pick == OWN_DC) ? DC_LEN : IC_LEN;
        ar_size_q <= (rd_pick == OWN_UC) ? uc_rd_size : 3'b010;
      end
    end
  end

  assign arvalid     = r_state == R_AR;
  assign araddr      = ar_addr_q;
  assign arlen       = ar_len_q;
  assign arsize      = ar_size_q;
  assign rd_hs       = arvalid && arready;
  assign ic_rd_gnt   = rd_hs && rd_owner == OWN_IC;
  assign dc_rd_gnt   = rd_hs && rd_owner == OWN_DC;
  assign uc_rd_gnt   = rd_hs && rd_owner == OWN_UC;
  assign rready      = r_state == R_DATA;
  assign rd_beat     = rready && rvalid;
  assign ic_rd_valid = rd_beat && rd_owner == OWN_IC;
  assign dc_rd_valid = rd_beat && rd_owner == OWN_DC;
  assign uc_rd_valid = rd_beat && rd_owner == OWN_UC;
  assign rd_last     = rd_beat && rlast;
  assign rd_data     = rd_beat ? rdata : '0;

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  w_next = (wr_pick != 2'd0) ? W_AW : W_IDLE;
      W_AW:    w_next = awready ? W_DATA : W_AW;
      W_DATA:  w_next = (wready && wlast) ? W_RESP : W_DATA;
      W_RESP:  w_next = bvalid ? W_IDLE : W_RESP;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state   <= W_IDLE;
      wr_owner  <= 2'd0;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      aw_size_q <= '0;
      beat      <= '0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && wr_pick != 2'd0) begin
        wr_owner  <= wr_pick;
        aw_addr_q <= (wr_pick == OWN_UC) ? uc_wr_addr : dc_wr_addr;
        aw_len_q  <= (wr_pick == OWN_UC) ? 8'd0 : DC_LEN;
        aw_size_q <= (wr_pick == OWN_UC) ? uc_wr_size : 3'b010;
        beat      <= '0;
      end else if (wr_beat) begin
        beat <= beat + 8'd1;
      end
    end
  end

  assign awvalid    = w_state == W_AW;
  assign awaddr     = aw_addr_q;
  assign awlen      = aw_len_q;
  assign awsize     = aw_size_q;
  assign wvalid     = w_state == W_DATA;
  assign wlast      = wvalid && beat == aw_len_q;
  assign wdata      = !wvalid ? '0 : (wr_owner == OWN_UC) ? uc_wr_data : dc_wr_data;
  assign wstrb      = !wvalid ? '0 : (wr_owner == OWN_UC) ? uc_wr_strb : dc_wr_strb;
  assign wr_beat    = wvalid && wready;
  assign dc_wr_next = wr_beat && wr_owner == OWN_DC;
  assign uc_wr_next = wr_beat && wr_owner == OWN_UC;
  assign bready     = w_state == W_RESP;
  assign wr_resp    = bready && bvalid;
  assign dc_wr_done = wr_resp && wr_owner == OWN_DC;
  assign uc_wr_done = wr_resp && wr_owner == OWN_UC;
endmodule

// File: tb/tb_axi_bus_arbiter.sv
// tb_axi_bus_arbiter: directed bench with bench-side AXI slave, requesters and a transaction-phase model.
`timescale 1ns/1ps
module tb_axi_bus_arbiter;
  localparam int ICW = 8, DCW = 8;
  localparam int IC = 1, DC = 2, UC = 3;

  logic clk = 0, resetn = 0;
  logic ic_rd_req, dc_rd_req, uc_rd_req;
  logic [31:0] ic_rd_addr, dc_rd_addr, uc_rd_addr;
  logic [2:0] uc_rd_size, uc_wr_size;
  logic ic_rd_gnt, dc_rd_gnt, uc_rd_gnt, ic_rd_valid, dc_rd_valid, uc_rd_valid, rd_last;
  logic [31:0] rd_data;
  logic dc_wr_req, uc_wr_req;
  logic [31:0] dc_wr_addr, uc_wr_addr, dc_wr_data, uc_wr_data;
  logic [3:0] dc_wr_strb, uc_wr_strb;
  logic dc_wr_next, uc_wr_next, dc_wr_done, uc_wr_done;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic [3:0] wstrb;
  logic wlast, wvalid, wready, bvalid, bready;

  axi_bus_arbiter #(.IC_LINE_WORDS(ICW), .DC_LINE_WORDS(DCW)) dut (
    .clk(clk), .resetn(resetn),
    .ic_rd_req(ic_rd_req), .dc_rd_req(dc_rd_req), .uc_rd_req(uc_rd_req),
    .ic_rd_addr(ic_rd_addr), .dc_rd_addr(dc_rd_addr), .uc_rd_addr(uc_rd_addr),
    .uc_rd_size(uc_rd_size), .uc_wr_size(uc_wr_size),
    .ic_rd_gnt(ic_rd_gnt), .dc_rd_gnt(dc_rd_gnt), .uc_rd_gnt(uc_rd_gnt),
    .ic_rd_valid(ic_rd_valid), .dc_rd_valid(dc_rd_valid), .uc_rd_valid(uc_rd_valid),
    .rd_last(rd_last), .rd_data(rd_data),
    .dc_wr_req(dc_wr_req), .uc_wr_req(uc_wr_req),
    .dc_wr_addr(dc_wr_addr), .uc_wr_addr(uc_wr_addr),
    .dc_wr_data(dc_wr_data), .uc_wr_data(uc_wr_data),
    .dc_wr_strb(dc_wr_strb), .uc_wr_strb(uc_wr_strb),
    .dc_wr_next(dc_wr_next), .uc_wr_next(uc_wr_next),
    .dc_wr_done(dc_wr_done), .uc_wr_done(uc_wr_done),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int ar_delay, aw_delay, ar_wait, aw_wait, r_beat, r_len, r_txn, dc_wb, uc_wb;
  bit r_toggle, w_toggle, r_ph, w_ph, r_active, b_pend;
  bit s_ar_hs, s_arvalid, s_r_hs, s_rlast, s_aw_hs, s_awvalid, s_w_hs, s_wlast, s_b_hs;
  bit s_ic_gnt, s_dc_gnt, s_uc_gnt, s_dc_next, s_uc_next, s_dc_done, s_uc_done;
  int s_arlen;
  // model: current owner per channel group, phase, beat index and latched request
  int m_ro, m_wo, m_wph, m_wb, m_rlen, m_wlen;
  bit m_rap;
  logic [31:0] m_raddr, m_waddr;
  logic [2:0] m_rsize, m_wsize;
  int cnt_gnt[4], cnt_val[4], cnt_next[4], cnt_done[4], t_done[4];
  int cnt_rlast, cnt_wlast_hs, nxt_at_last, overlap, t_first_arv, t_last_beat, t_b_hs, t0;
  int log_own[8], log_len[8], log_size[8], log_t[8], n_log;
  logic [31:0] log_addr[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clr_stats();
    foreach (cnt_gnt[i]) begin
      cnt_gnt[i] = 0; cnt_val[i] = 0; cnt_next[i] = 0; cnt_done[i] = 0; t_done[i] = -1;
    end
    cnt_rlast = 0; cnt_wlast_hs = 0; nxt_at_last = -1; overlap = 0;
    t_first_arv = -1; t_last_beat = -1; t_b_hs = -1; n_log = 0;
  endtask

  task automatic check_cycle();
    int p;
    bit e_arv, e_rr, e_rb, e_awv, e_wv, e_br;
    logic [31:0] e_wd;
    #2;
    cyc++;
    if (!resetn) begin
      chk("reset_ctrl", {arvalid, rready, awvalid, wvalid, wlast, bready, ic_rd_gnt, dc_rd_gnt,
          uc_rd_gnt, ic_rd_valid, dc_rd_valid, uc_rd_valid, rd_last, dc_wr_next, uc_wr_next,
          dc_wr_done, uc_wr_done}, 0);
      chk("reset_araddr", araddr, 0);
      chk("reset_awaddr", awaddr, 0);
      chk("reset_lens", {arlen, awlen}, 0);
      m_ro = 0; m_wo = 0; m_rap = 0; m_wph = 0; m_wb = 0;
      {s_ar_hs, s_arvalid, s_r_hs, s_rlast, s_aw_hs, s_awvalid, s_w_hs, s_wlast, s_b_hs} = '0;
      {s_ic_gnt, s_dc_gnt, s_uc_gnt, s_dc_next, s_uc_next, s_dc_done, s_uc_done} = '0;
      return;
    end
    e_arv = m_ro != 0 && m_rap;
    chk("arvalid", arvalid, e_arv);
    if (e_arv) begin
      chk("araddr", araddr, m_raddr);
      chk("arlen", arlen, m_rlen);
      chk("arsize", arsize, m_rsize);
    end
    chk("ic_rd_gnt", ic_rd_gnt, e_arv && arready && m_ro == IC);
    chk("dc_rd_gnt", dc_rd_gnt, e_arv && arready && m_ro == DC);
    chk("uc_rd_gnt", uc_rd_gnt, e_arv && arready && m_ro == UC);
    e_rr = m_ro != 0 && !m_rap;
    e_rb = e_rr && rvalid;
    chk("rready", rready, e_rr);
    chk("ic_rd_valid", ic_rd_valid, e_rb && m_ro == IC);
    chk("dc_rd_valid", dc_rd_valid, e_rb && m_ro == DC);
    chk("uc_rd_valid", uc_rd_valid, e_rb && m_ro == UC);
    chk("rd_last", rd_last, e_rb && rlast);
    if (e_rb) chk("rd_data", rd_data, rdata);
    e_awv = m_wo != 0 && m_wph == 0;
    chk("awvalid", awvalid, e_awv);
    if (e_awv) begin
      chk("awaddr", awaddr, m_waddr);
      chk("awlen", awlen, m_wlen);
      chk("awsize", awsize, m_wsize);
    end
    e_wv = m_wo != 0 && m_wph == 1;
    chk("wvalid", wvalid, e_wv);
    if (e_wv) begin
      e_wd = (m_wo == UC) ? 32'h5500_0000 + m_wb : 32'hC000_0000 + m_wb;
      chk("wlast", wlast, m_wb == m_wlen);
      chk("wdata", wdata, e_wd);
      chk("wstrb", wstrb, (m_wo == UC) ? uc_wr_strb : dc_wr_strb);
    end
    chk("dc_wr_next", dc_wr_next, e_wv && wready && m_wo == DC);
    chk("uc_wr_next", uc_wr_next, e_wv && wready && m_wo == UC);
    e_br = m_wo != 0 && m_wph == 2;
    chk("bready", bready, e_br);
    chk("dc_wr_done", dc_wr_done, e_br && bvalid && m_wo == DC);
    chk("uc_wr_done", uc_wr_done, e_br && bvalid && m_wo == UC);
    // observations for bench agents and per-test literal checks
    s_arvalid = arvalid; s_ar_hs = arvalid && arready; s_arlen = int'(arlen);
    s_r_hs = rvalid && rready; s_rlast = rlast;
    s_awvalid = awvalid; s_aw_hs = awvalid && awready;
    s_w_hs = wvalid && wready; s_wlast = wlast; s_b_hs = bvalid && bready;
    s_ic_gnt = ic_rd_gnt; s_dc_gnt = dc_rd_gnt; s_uc_gnt = uc_rd_gnt;
    s_dc_next = dc_wr_next; s_uc_next = uc_wr_next; s_dc_done = dc_wr_done; s_uc_done = uc_wr_done;
    if (arvalid && t_first_arv < 0) t_first_arv = cyc;
    if (arvalid && arready && n_log < 8) begin
      log_own[n_log] = uc_rd_gnt ? UC : dc_rd_gnt ? DC : ic_rd_gnt ? IC : 0;
      log_len[n_log] = int'(arlen); log_size[n_log] = int'(arsize);
      log_addr[n_log] = araddr; log_t[n_log] = cyc; n_log++;
    end
    cnt_gnt[IC] += int'(ic_rd_gnt); cnt_gnt[DC] += int'(dc_rd_gnt); cnt_gnt[UC] += int'(uc_rd_gnt);
    cnt_val[IC] += int'(ic_rd_valid); cnt_val[DC] += int'(dc_rd_valid); cnt_val[UC] += int'(uc_rd_valid);
    if (rd_last) begin cnt_rlast++; t_last_beat = cyc; end
    if (wvalid && wready && wlast) begin cnt_wlast_hs++; nxt_at_last = cnt_next[DC] + cnt_next[UC]; end
    cnt_next[DC] += int'(dc_wr_next); cnt_next[UC] += int'(uc_wr_next);
    if (bvalid && bready) t_b_hs = cyc;
    if (dc_wr_done) begin cnt_done[DC]++; t_done[DC] = cyc; end
    if (uc_wr_done) begin cnt_done[UC]++; t_done[UC] = cyc; end
    if (rready && wvalid) overlap++;
    // advance model: read group (uses the write owner as it stands this cycle)
    if (m_ro == 0) begin
      p = (uc_rd_req && m_wo != UC) ? UC : dc_rd_req ? DC : ic_rd_req ? IC : 0;
      if (p != 0) begin
        m_ro = p; m_rap = 1;
        m_raddr = (p == UC) ? uc_rd_addr : (p == DC) ? dc_rd_addr : ic_rd_addr;
        m_rlen = (p == UC) ? 0 : (p == DC) ? DCW - 1 : ICW - 1;
        m_rsize = (p == UC) ? uc_rd_size : 3'd2;
      end
    end else if (m_rap) begin
      if (arready) m_rap = 0;
    end else if (rvalid && rlast) m_ro = 0;
    if (m_wo == 0) begin
      p = uc_wr_req ? UC : dc_wr_req ? DC : 0;
      if (p != 0) begin
        m_wo = p; m_wph = 0; m_wb = 0;
        m_waddr = (p == UC) ? uc_wr_addr : dc_wr_addr;
        m_wlen = (p == UC) ? 0 : DCW - 1;
        m_wsize = (p == UC) ? uc_wr_size : 3'd2;
      end
    end else if (m_wph == 0) begin
      if (awready) m_wph = 1;
    end else if (m_wph == 1) begin
      if (wready) begin
        if (m_wb == m_wlen) m_wph = 2;
        else m_wb++;
      end
    end else if (bvalid) m_wo = 0;
  endtask

  task automatic agents();
    if (!resetn) begin
      {ic_rd_req, dc_rd_req, uc_rd_req, dc_wr_req, uc_wr_req} = '0;
      {arready, rvalid, rlast, awready, wready, bvalid} = '0;
      rdata = '0; r_active = 0; b_pend = 0; ar_wait = 0; aw_wait = 0; dc_wb = 0; uc_wb = 0;
      return;
    end
    if (s_ic_gnt) ic_rd_req = 0;
    if (s_dc_gnt) dc_rd_req = 0;
    if (s_uc_gnt) uc_rd_req = 0;
    if (s_dc_next) dc_wb++;
    if (s_uc_next) uc_wb++;
    if (s_dc_done) begin dc_wr_req = 0; dc_wb = 0; end
    if (s_uc_done) begin uc_wr_req = 0; uc_wb = 0; end
    dc_wr_data = 32'hC000_0000 + dc_wb;
    uc_wr_data = 32'h5500_0000 + uc_wb;
    if (s_ar_hs) begin r_active = 1; r_len = s_arlen; r_beat = 0; ar_wait = 0; end
    else if (s_arvalid) ar_wait++;
    if (s_r_hs) begin
      if (s_rlast) begin r_active = 0; r_txn++; end
      else r_beat++;
    end
    r_ph = !r_ph;
    arready = arvalid && ar_wait >= ar_delay;
    rvalid = r_active && (!r_toggle || r_ph);
    rlast = rvalid && r_beat == r_len;
    rdata = rvalid ? 32'hD000_0000 | (r_txn << 8) | r_beat : 32'h0;
    if (s_aw_hs) aw_wait = 0;
    else if (s_awvalid) aw_wait++;
    if (s_w_hs && s_wlast) b_pend = 1;
    if (s_b_hs) b_pend = 0;
    w_ph = !w_ph;
    awready = awvalid && aw_wait >= aw_delay;
    wready = wvalid && (!w_toggle || w_ph);
    bvalid = b_pend;
  endtask

  task automatic tick();
    check_cycle();
    @(negedge clk);
    agents();
  endtask

  function automatic bit idle();
    return m_ro == 0 && m_wo == 0 && !r_active && !b_pend &&
           !(ic_rd_req || dc_rd_req || uc_rd_req || dc_wr_req || uc_wr_req);
  endfunction

  task automatic run_until_idle(input string nm, input int max);
    int k = 0;
    while (!idle() && k < max) begin tick(); k++; end
    chk(nm, idle(), 1);
  endtask

  initial begin
    {ic_rd_req, dc_rd_req, uc_rd_req, dc_wr_req, uc_wr_req} = '0;
    {ic_rd_addr, dc_rd_addr, uc_rd_addr, dc_wr_addr, uc_wr_addr} = '0;
    {uc_rd_size, uc_wr_size} = '0;
    dc_wr_data = '0; uc_wr_data = '0; dc_wr_strb = 4'hF; uc_wr_strb = '0;
    {arready, rvalid, rlast, awready, wready, bvalid} = '0; rdata = '0;
    ar_delay = 0; aw_delay = 0; r_toggle = 0; w_toggle = 0; r_txn = 0;
    clr_stats();
    @(negedge clk);
    tick(); tick();
    resetn = 1;
    tick();

    // single ICache refill, arready after two waiting cycles
    clr_stats(); ar_delay = 2;
    ic_rd_addr = 32'h1FC0_0000; ic_rd_req = 1; t0 = cyc + 1;
    run_until_idle("t1_idle", 60);
    chk("t1_arvalid_latency", t_first_arv, t0 + 1);
    chk("t1_ar_count", n_log, 1);
    chk("t1_owner", log_own[0], IC);
    chk("t1_arlen", log_len[0], 7);
    chk("t1_arsize", log_size[0], 2);
    chk("t1_araddr", log_addr[0], 32'h1FC0_0000);
    chk("t1_ar_hs_cycle", log_t[0], t0 + 3);
    chk("t1_gnt_count", cnt_gnt[IC] + cnt_gnt[DC] + cnt_gnt[UC], 1);
    chk("t1_ic_beats", cnt_val[IC], 8);
    chk("t1_rd_last_count", cnt_rlast, 1);
    chk("t1_last_beat_cycle", t_last_beat, t0 + 11);

    // three reads in the same cycle: uc, then dc, then ic
    clr_stats(); ar_delay = 0;
    uc_rd_addr = 32'h8000_0004; uc_rd_size = 3'd0;
    dc_rd_addr = 32'h0000_2000; ic_rd_addr = 32'h1FC0_0100;
    uc_rd_req = 1; dc_rd_req = 1; ic_rd_req = 1;
    run_until_idle("t2_idle", 100);
    chk("t2_ar_count", n_log, 3);
    chk("t2_own0", log_own[0], UC);
    chk("t2_own1", log_own[1], DC);
    chk("t2_own2", log_own[2], IC);
    chk("t2_len0", log_len[0], 0);
    chk("t2_len1", log_len[1], 7);
    chk("t2_len2", log_len[2], 7);
    chk("t2_size0", log_size[0], 0);
    chk("t2_beats", {cnt_val[UC][7:0], cnt_val[DC][7:0], cnt_val[IC][7:0]}, 32'h00_01_08_08);
    chk("t2_gnts", {cnt_gnt[UC][7:0], cnt_gnt[DC][7:0], cnt_gnt[IC][7:0]}, 32'h00_01_01_01);

    // DCache writeback with wready toggling
    clr_stats(); w_toggle = 1; aw_delay = 1;
    dc_wr_addr = 32'h0000_1000; dc_wr_strb = 4'hF; dc_wr_req = 1;
    run_until_idle("t3_idle", 100);
    chk("t3_next_count", cnt_next[DC], 8);
    chk("t3_wlast_count", cnt_wlast_hs, 1);
    chk("t3_wlast_beat", nxt_at_last, 7);
    chk("t3_done_count", cnt_done[DC], 1);
    chk("t3_done_on_b", t_done[DC], t_b_hs);
    chk("t3_uc_next", cnt_next[UC], 0);

    // uncached store then load: load held back, dc read proceeds meanwhile
    clr_stats(); w_toggle = 0; aw_delay = 12;
    uc_wr_addr = 32'hBFD0_0010; uc_wr_size = 3'd2; uc_wr_strb = 4'b0011; uc_wr_req = 1;
    tick();
    uc_rd_addr = 32'hBFD0_0020; uc_rd_size = 3'd2; uc_rd_req = 1;
    dc_rd_addr = 32'h0000_3000; dc_rd_req = 1;
    run_until_idle("t4_idle", 100);
    chk("t4_ar_count", n_log, 2);
    chk("t4_own0", log_own[0], DC);
    chk("t4_own1", log_own[1], UC);
    chk("t4_dc_before_wdone", log_t[0] < t_done[UC], 1);
    chk("t4_uc_ar_cycle", log_t[1], t_done[UC] + 2);
    chk("t4_uc_done", cnt_done[UC], 1);
    chk("t4_uc_beat", cnt_val[UC], 1);

    // concurrent dc write and ic read
    clr_stats(); ar_delay = 1; aw_delay = 0; r_toggle = 1;
    dc_wr_addr = 32'h0000_4000; dc_wr_req = 1;
    ic_rd_addr = 32'h1FC0_0300; ic_rd_req = 1;
    run_until_idle("t5_idle", 100);
    chk("t5_overlap", overlap > 0, 1);
    chk("t5_ic_beats", cnt_val[IC], 8);
    chk("t5_dc_next", cnt_next[DC], 8);
    chk("t5_dc_valid", cnt_val[DC], 0);
    chk("t5_uc_next", cnt_next[UC], 0);
    chk("t5_dc_done", cnt_done[DC], 1);

    // reset during the third beat, then a clean restart
    clr_stats(); ar_delay = 0; r_toggle = 0;
    ic_rd_addr = 32'h1FC0_0400; ic_rd_req = 1;
    for (int k = 0; k < 40 && cnt_val[IC] < 2; k++) tick();
    chk("t6_two_beats", cnt_val[IC], 2);
    chk("t6_beat3_pending", rvalid, 1);
    resetn = 0;
    tick();
    tick();
    resetn = 1;
    clr_stats();
    ic_rd_addr = 32'h1FC0_0500; ic_rd_req = 1; t0 = cyc + 1;
    run_until_idle("t6_idle", 60);
    chk("t6_arvalid_latency", t_first_arv, t0 + 1);
    chk("t6_ar_count", n_log, 1);
    chk("t6_araddr", log_addr[0], 32'h1FC0_0500);
    chk("t6_ic_beats", cnt_val[IC], 8);
    chk("t6_gnt", cnt_gnt[IC], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
